// File: rtl/digclk_set_ctrl.sv
// Run/set sequencer for the digital clock: conditions the raw buttons and switch,
// produces the seconds enable, seconds clear and minute adjust pulses with auto-repeat.
module digclk_set_ctrl #(
  parameter int CLK_HZ           = 100_000_000,
  parameter int TICK_CYC         = 100_000_000,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic clk_100M,
  input  logic reset,
  input  logic incr_pb,
  input  logic decr_pb,
  input  logic min_set_switch,
  output logic sec_tick,
  output logic sec_clr,
  output logic min_incr,
  output logic min_decr,
  output logic set_mode
);

  localparam int TICK_W  = $clog2(TICK_CYC + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  if (CLK_HZ < 1 || TICK_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_bad_params
    $error("digclk_set_ctrl: CLK_HZ, TICK_CYC and DEBOUNCE_CYC must be positive");
  end

  typedef enum logic [1:0] {RUN, SET_IDLE, INC_HOLD, DEC_HOLD} state_t;

  // Bit 0 = increment, bit 1 = decrement, bit 2 = set switch.
  logic [2:0] raw_in;
  logic [2:0] deb_lvl;
  assign raw_in = {min_set_switch, decr_pb, incr_pb};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cond
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk_100M or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_in[gi];
        sync2_q <= sync1_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DEB_W'(1);
        end
      end
    end

    assign deb_lvl[gi] = deb_q;
  end

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [RPT_W-1:0]    rpt_q, rpt_d;
  logic [1:0]          deb_prev_q;
  logic                tick_q, tick_d;
  logic                clr_q, clr_d;
  logic                inc_q, inc_d;
  logic                dec_q, dec_d;
  logic                set_q, set_d;
  logic                rise_inc, rise_dec, held;

  assign rise_inc = deb_lvl[0] & ~deb_prev_q[0];
  assign rise_dec = deb_lvl[1] & ~deb_prev_q[1];
  assign held     = (state_q == INC_HOLD) ? deb_lvl[0] : deb_lvl[1];

  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    presc_d = '0;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (deb_lvl[2]) begin
          state_d = SET_IDLE;
          clr_d   = 1'b1;
        end
      end
      SET_IDLE: begin
        if (!deb_lvl[2]) begin
          state_d = RUN;
        end else if (rise_inc && !rise_dec) begin
          state_d = INC_HOLD;
          inc_d   = 1'b1;
          rpt_d   = RPT_W'(REPEAT_DELAY_CYC);
        end else if (rise_dec && !rise_inc) begin
          state_d = DEC_HOLD;
          dec_d   = 1'b1;
          rpt_d   = RPT_W'(REPEAT_DELAY_CYC);
        end
      end
      INC_HOLD, DEC_HOLD: begin
        // Leaving set mode wins over a repeat falling due in the same cycle.
        if (!deb_lvl[2]) begin
          state_d = RUN;
        end else if (!held) begin
          state_d = SET_IDLE;
        end else if (rpt_q <= RPT_W'(1)) begin
          inc_d = (state_q == INC_HOLD);
          dec_d = (state_q == DEC_HOLD);
          rpt_d = RPT_W'(REPEAT_RATE_CYC);
        end else begin
          rpt_d = rpt_q - RPT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // Prescaler only runs while staying in RUN, so it restarts from 0 on SET exit.
    if (state_q == RUN && state_d == RUN) begin
      if (presc_q == TICK_W'(TICK_CYC - 1)) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end
    set_d = (state_d != RUN);
  end

  always_ff @(posedge clk_100M or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      presc_q    <= '0;
      rpt_q      <= '0;
      deb_prev_q <= '0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      set_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rpt_q      <= rpt_d;
      deb_prev_q <= deb_lvl[1:0];
      tick_q     <= tick_d;
      clr_q      <= clr_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      set_q      <= set_d;
    end
  end

  assign sec_tick = tick_q;
  assign sec_clr  = clr_q;
  assign min_incr = inc_q;
  assign min_decr = dec_q;
  assign set_mode = set_q;

endmodule

// File: tb/tb_digclk_set_ctrl.sv
// Self-checking bench for digclk_set_ctrl with small timing parameters and a
// cycle-stamped behavioural reference model.
module tb_digclk_set_ctrl;

  localparam int TICK = 10;
  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic incr_pb = 1'b0;
  logic decr_pb = 1'b0;
  logic sw = 1'b0;
  logic sec_tick, sec_clr, min_incr, min_decr, set_mode;
  logic [4:0] dut_o;

  int checks = 0;
  int errors = 0;

  assign dut_o = {set_mode, min_decr, min_incr, sec_clr, sec_tick};

  always #5 clk = ~clk;

  digclk_set_ctrl #(
    .TICK_CYC(TICK), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut (
    .clk_100M(clk), .reset(rst_n), .incr_pb(incr_pb), .decr_pb(decr_pb),
    .min_set_switch(sw), .sec_tick(sec_tick), .sec_clr(sec_clr),
    .min_incr(min_incr), .min_decr(min_decr), .set_mode(set_mode)
  );

  // Reference model: a level is accepted once its last DEB synchronised samples all
  // disagree with the current accepted level; events are scheduled by absolute cycle.
  int t, mode, run_entry, next_rep;   // mode: 0 run, 1 set idle, 2 inc hold, 3 dec hold
  bit deb [3];
  bit prev [3];
  bit hist [3][DEB+1];
  bit ri, rd, held, diff;
  logic [4:0] e;
  logic [4:0] exp_o = 5'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0; mode = 0; run_entry = 0; next_rep = 0; exp_o = 5'b0;
        for (int i = 0; i < 3; i++) begin
          deb[i] = 1'b0; prev[i] = 1'b0;
          for (int k = 0; k <= DEB; k++) hist[i][k] = 1'b0;
        end
      end else begin
        t = t + 1;
        e = 5'b0;
        ri = deb[0] && !prev[0];
        rd = deb[1] && !prev[1];
        case (mode)
          0: begin
            if (deb[2]) begin mode = 1; e[1] = 1'b1; end
            else if ((t - run_entry) % TICK == 0) e[0] = 1'b1;
          end
          1: begin
            if (!deb[2]) begin mode = 0; run_entry = t; end
            else if (ri && !rd) begin e[2] = 1'b1; mode = 2; next_rep = t + RD; end
            else if (rd && !ri) begin e[3] = 1'b1; mode = 3; next_rep = t + RD; end
          end
          default: begin
            held = (mode == 2) ? deb[0] : deb[1];
            if (!deb[2]) begin mode = 0; run_entry = t; end
            else if (!held) mode = 1;
            else if (t == next_rep) begin
              if (mode == 2) e[2] = 1'b1; else e[3] = 1'b1;
              next_rep = t + RR;
            end
          end
        endcase
        e[4] = (mode != 0);
        exp_o = e;
        for (int i = 0; i < 3; i++) begin
          prev[i] = deb[i];
          diff = 1'b1;
          for (int k = 1; k <= DEB; k++) if (hist[i][k] == deb[i]) diff = 1'b0;
          if (diff) deb[i] = !deb[i];
          for (int k = DEB; k > 0; k--) hist[i][k] = hist[i][k-1];
        end
        hist[0][0] = incr_pb; hist[1][0] = decr_pb; hist[2][0] = sw;
      end
    end
  end

  task automatic test_reset();
    incr_pb = 0; decr_pb = 0; sw = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_o !== 5'b0) begin
      errors++; $display("FAIL reset_async: outputs=%b expected=%b", dut_o, 5'b0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (dut_o !== 5'b0) begin
      errors++; $display("FAIL reset_held: outputs=%b expected=%b", dut_o, 5'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_ticks();
    int ticks[$];
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL run_ticks: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (sec_tick) ticks.push_back(k);
    end
    checks++;
    if (ticks.size() != 3) begin
      errors++; $display("FAIL run_tick_count: got %0d expected 3", ticks.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ticks.size() || ticks[i] != TICK * (i + 1)) begin
        errors++; $display("FAIL run_tick_pos: tick %0d at %0d expected %0d", i,
                           (i < ticks.size()) ? ticks[i] : -1, TICK * (i + 1));
      end
    end
  endtask

  task automatic test_set_entry();
    int clr_at = 0, set_at = 0, run_at = 0, tick_at = 0;
    @(negedge clk);
    sw = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL set_entry: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (sec_clr && clr_at == 0) clr_at = k;
      if (set_mode && set_at == 0) set_at = k;
    end
    checks++;
    if (clr_at != 7) begin errors++; $display("FAIL sec_clr_latency: got %0d expected 7", clr_at); end
    checks++;
    if (set_at != 7) begin errors++; $display("FAIL set_mode_latency: got %0d expected 7", set_at); end
    sw = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL set_exit: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (!set_mode && run_at == 0) run_at = k;
      if (sec_tick && tick_at == 0) tick_at = k;
    end
    checks++;
    if (run_at != 7) begin errors++; $display("FAIL run_reentry: got %0d expected 7", run_at); end
    checks++;
    if (tick_at != 17) begin errors++; $display("FAIL tick_after_exit: got %0d expected 17", tick_at); end
  endtask

  task automatic test_bounce_incr();
    int lv [9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
    int ln [9] = '{0, 2, 1, 3, 2, 1, 1, 10, 15};
    int inc_n = 0, dec_n = 0;
    sw = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL bounce_setup: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
    end
    for (int s = 1; s < 9; s++) begin
      incr_pb = lv[s][0];
      for (int j = 0; j < ln[s]; j++) begin
        @(negedge clk);
        checks++;
        if (dut_o !== exp_o) begin
          errors++; $display("FAIL bounce_incr: seg %0d outputs=%b expected=%b", s, dut_o, exp_o);
        end
        if (min_incr) inc_n++;
        if (min_decr) dec_n++;
      end
    end
    checks++;
    if (inc_n != 1) begin errors++; $display("FAIL bounce_incr_count: got %0d expected 1", inc_n); end
    checks++;
    if (dec_n != 0) begin errors++; $display("FAIL bounce_decr_count: got %0d expected 0", dec_n); end
  endtask

  task automatic test_hold_decr();
    int exp_p [5] = '{7, 27, 32, 37, 42};
    int pulses[$];
    int inc_n = 0;
    decr_pb = 1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL hold_decr: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (min_decr) pulses.push_back(k);
      if (min_incr) inc_n++;
      if (k == 40) decr_pb = 0;
    end
    checks++;
    if (pulses.size() != 5) begin
      errors++; $display("FAIL hold_decr_count: got %0d expected 5", pulses.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= pulses.size() || pulses[i] != exp_p[i]) begin
        errors++; $display("FAIL hold_decr_pos: pulse %0d at %0d expected %0d", i,
                           (i < pulses.size()) ? pulses[i] : -1, exp_p[i]);
      end
    end
    checks++;
    if (inc_n != 0) begin errors++; $display("FAIL hold_decr_incr: got %0d expected 0", inc_n); end
  endtask

  task automatic test_both_and_run();
    int set_n = 0, run_n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL both_run: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (k <= 20 && (min_incr || min_decr)) set_n++;
      if (k > 20 && min_incr) run_n++;
      if (k == 1) begin incr_pb = 1; decr_pb = 1; end
      if (k == 10) begin incr_pb = 0; decr_pb = 0; end
      if (k == 20) sw = 0;
      if (k == 30) incr_pb = 1;
      if (k == 42) incr_pb = 0;
    end
    checks++;
    if (set_n != 0) begin errors++; $display("FAIL both_pressed: got %0d pulses expected 0", set_n); end
    checks++;
    if (run_n != 0) begin errors++; $display("FAIL run_ignore_incr: got %0d pulses expected 0", run_n); end
  endtask

  task automatic test_reset_mid_hold();
    int dec_n = 0, clr_at = 0;
    sw = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL mid_hold_setup: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (k == 10) decr_pb = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_o !== 5'b0) begin
      errors++; $display("FAIL mid_hold_reset: outputs=%b expected=%b", dut_o, 5'b0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL after_reset: cycle %0d outputs=%b expected=%b", k, dut_o, exp_o);
      end
      if (min_decr) dec_n++;
      if (sec_clr && clr_at == 0) clr_at = k;
    end
    checks++;
    if (dec_n != 0) begin errors++; $display("FAIL reset_pulse_lost: got %0d expected 0", dec_n); end
    checks++;
    if (clr_at != 7) begin errors++; $display("FAIL requalify_switch: got %0d expected 7", clr_at); end
    decr_pb = 0; sw = 0;
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 40; s++) begin
      sw      = ($urandom_range(0, 3) != 0);
      incr_pb = $urandom_range(0, 1);
      decr_pb = $urandom_range(0, 1);
      len     = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        checks++;
        if (dut_o !== exp_o) begin
          errors++; $display("FAIL random: seg %0d outputs=%b expected=%b", s, dut_o, exp_o);
        end
        checks++;
        if ((min_incr && min_decr) || (sec_tick && set_mode)) begin
          errors++; $display("FAIL random_exclusive: outputs=%b expected no overlap", dut_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_set_entry();
    test_bounce_incr();
    test_hold_decr();
    test_both_and_run();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
